// File: rtl/cond_logic.sv
// Condition-check and flag unit: holds architectural NZCV, decodes the condition
// field, and gates PC/register/memory write enables with a latched condition result.
module cond_logic (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       CondLatch,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    output logic [3:0] Flags,
    output logic       CondEx,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite
);

    logic [3:0] r_flags;
    logic       r_cond_ex_delayed;
    logic       w_cond_ex;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Decode uses only the registered flags, never this cycle's ALU result.
    always_comb begin
        w_cond_ex = 1'b0;
        case (Cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    // Flag halves and the delayed condition all sample the pre-edge w_cond_ex.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags           <= 4'b0000;
            r_cond_ex_delayed <= 1'b0;
        end else begin
            if (FlagW[1] && w_cond_ex) begin
                r_flags[3:2] <= ALUFlags[3:2];
            end
            if (FlagW[0] && w_cond_ex) begin
                r_flags[1:0] <= ALUFlags[1:0];
            end
            if (CondLatch) begin
                r_cond_ex_delayed <= w_cond_ex;
            end
        end
    end

    assign Flags    = r_flags;
    assign CondEx   = w_cond_ex;
    assign PCWrite  = (PCS & r_cond_ex_delayed) | NextPC;
    assign RegWrite = RegW & r_cond_ex_delayed;
    assign MemWrite = MemW & r_cond_ex_delayed;

endmodule

// File: tb/tb_cond_logic.sv
// Directed-vector bench for cond_logic: the driver pushes hand-computed expectations,
// a monitor pops and compares them against {Flags, CondEx, PCWrite, RegWrite, MemWrite}.
module tb_cond_logic;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       CondLatch;
    logic       PCS;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic [3:0] Flags;
    logic       CondEx;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;

    cond_logic dut (
        .clk       (clk),
        .reset     (reset),
        .Cond      (Cond),
        .ALUFlags  (ALUFlags),
        .FlagW     (FlagW),
        .CondLatch (CondLatch),
        .PCS       (PCS),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Flags     (Flags),
        .CondEx    (CondEx),
        .PCWrite   (PCWrite),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state; output vector is {Flags[3:0], CondEx, PCWrite, RegWrite, MemWrite}
    logic [7:0] exp_q[$];
    logic [7:0] mask_q[$];
    string      tag_q[$];
    int         n_pending = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] w_out;

    assign w_out = {Flags, CondEx, PCWrite, RegWrite, MemWrite};

    localparam logic [7:0] ALL   = 8'hFF;
    localparam logic [7:0] CONDM = 8'hF8;

    // Driver tasks
    task automatic drive(input logic [3:0] cond, input logic [3:0] aluf, input logic [1:0] fw,
                         input logic latch, input logic pcs, input logic npc,
                         input logic regw, input logic memw);
        Cond      = cond;
        ALUFlags  = aluf;
        FlagW     = fw;
        CondLatch = latch;
        PCS       = pcs;
        NextPC    = npc;
        RegW      = regw;
        MemW      = memw;
    endtask

    task automatic push_exp(input string tag, input logic [7:0] mask, input logic [7:0] exp);
        tag_q.push_back(tag);
        mask_q.push_back(mask);
        exp_q.push_back(exp);
        n_pending++;
    endtask

    task automatic sample(input string tag, input logic [7:0] mask, input logic [7:0] exp);
        @(negedge clk);
        push_exp(tag, mask, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor
    initial begin
        string      t;
        logic [7:0] m;
        logic [7:0] e;
        forever begin
            wait (n_pending > 0);
            t = tag_q.pop_front();
            m = mask_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if ((w_out & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b (mask %b)", t, w_out & m, e & m, m);
            end
            n_pending--;
        end
    end

    // Stimulus
    logic [3:0]  sweep_flags [3];
    logic [15:0] sweep_exp   [3];

    initial begin
        logic [15:0] tbl;
        int          waited;

        sweep_flags[0] = 4'b1001; sweep_exp[0] = 16'h565A;
        sweep_flags[1] = 4'b0110; sweep_exp[1] = 16'h66A5;
        sweep_flags[2] = 4'b0010; sweep_exp[2] = 16'h55A6;

        reset = 1'b0;
        drive(4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        sample("reset_idle", ALL, 8'b0000_0000);
        #1;
        drive(4'b1110, 4'b1111, 2'b11, 1, 1, 1, 1, 1);
        sample("reset_gates", ALL, 8'b0000_1100);
        #1;
        drive(4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        #1 reset = 1'b1;
        next_cycle();

        // AL with FlagW=11 loads 0100; then EQ sees Z=1
        drive(4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0, 0);
        sample("al_before_load", ALL, 8'b0000_1000);
        next_cycle();
        drive(4'b0000, 4'b1111, 2'b00, 0, 0, 0, 0, 0);
        sample("eq_after_load", ALL, 8'b0100_1000);
        next_cycle();

        // FlagW=00 ignores ALUFlags; FlagW=10 updates N,Z only
        drive(4'b1110, 4'b1011, 2'b10, 0, 0, 0, 0, 0);
        sample("flagw00_held", ALL, 8'b0100_1000);
        next_cycle();
        drive(4'b1110, 4'b0111, 2'b01, 0, 0, 0, 0, 0);
        sample("flagw10_nz_only", ALL, 8'b1000_1000);
        next_cycle();
        drive(4'b1110, 4'b0000, 2'b11, 0, 0, 0, 0, 0);
        sample("flagw01_cv_only", ALL, 8'b1011_1000);
        next_cycle();

        // Flags=0000, EQ fails: no flag write, nothing latched
        drive(4'b0000, 4'b1111, 2'b11, 1, 1, 0, 1, 1);
        sample("eq_fail_pre", ALL, 8'b0000_0000);
        next_cycle();
        drive(4'b1110, 4'b1111, 2'b00, 1, 1, 0, 1, 1);
        sample("eq_fail_gated", ALL, 8'b0000_1000);
        next_cycle();
        drive(4'b0000, 4'b0000, 2'b00, 0, 1, 0, 1, 1);
        sample("latched_al_enables", ALL, 8'b0000_0111);
        next_cycle();

        // Latch and flag update on the same edge: latch keeps the pre-edge NE result
        drive(4'b0001, 4'b0100, 2'b11, 1, 0, 0, 1, 0);
        sample("same_edge_pre", ALL, 8'b0000_1010);
        next_cycle();
        drive(4'b0001, 4'b0000, 2'b00, 0, 0, 0, 1, 0);
        sample("same_edge_post", ALL, 8'b0100_0010);
        next_cycle();

        // NextPC forces PCWrite while the latched condition is 0
        drive(4'b0001, 4'b0000, 2'b00, 1, 1, 1, 1, 1);
        next_cycle();
        drive(4'b0001, 4'b0000, 2'b00, 0, 1, 1, 1, 1);
        sample("nextpc_forces", ALL, 8'b0100_0100);
        next_cycle();
        drive(4'b0001, 4'b0000, 2'b00, 0, 1, 0, 1, 1);
        sample("pcs_gated_off", ALL, 8'b0100_0000);
        next_cycle();

        // Full condition sweeps against several flag values
        for (int s = 0; s < 3; s++) begin
            drive(4'b1110, sweep_flags[s], 2'b11, 0, 0, 0, 0, 0);
            next_cycle();
            tbl = sweep_exp[s];
            for (int c = 0; c < 16; c++) begin
                drive(c[3:0], 4'b0000, 2'b00, 0, 0, 0, 0, 0);
                sample($sformatf("sweep_f%b_c%b", sweep_flags[s], c[3:0]), CONDM,
                       {sweep_flags[s], tbl[c], 3'b000});
                next_cycle();
            end
        end

        // Asynchronous reset between edges discards the latched condition
        drive(4'b1110, 4'b1111, 2'b11, 1, 0, 0, 1, 1);
        next_cycle();
        drive(4'b1110, 4'b0000, 2'b00, 0, 0, 0, 1, 1);
        sample("pre_async_reset", ALL, 8'b1111_1011);
        #2 reset = 1'b0;
        #1 push_exp("async_reset_now", ALL, 8'b0000_1000);
        #1;
        drive(4'b0000, 4'b0100, 2'b11, 1, 0, 0, 1, 1);
        #1 reset = 1'b1;
        next_cycle();
        sample("first_edge_after_reset", ALL, 8'b0000_0000);
        next_cycle();

        waited = 0;
        while (n_pending != 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        if (n_pending != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", n_pending);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
